// File: rtl/apb_timer_slave.sv
// Zero-wait-state APB timer slave: prescaled down-counter with reload, sticky
// expiry flag, level interrupt, scratch and ID registers.
module apb_timer_slave #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          WIDTH     = 16,
    parameter logic [31:0] ID_VALUE  = 32'hA9B0_0001
) (
    input  logic        Hclk,
    input  logic        Hrstn,
    input  logic        Pselx,
    input  logic        Penable,
    input  logic        Pwrite,
    input  logic [31:0] Paddr,
    input  logic [31:0] Pwdata,
    output logic [31:0] Prdata,
    output logic        irq
);

    localparam logic [2:0] REG_CTRL    = 3'd0;
    localparam logic [2:0] REG_LOAD    = 3'd1;
    localparam logic [2:0] REG_VALUE   = 3'd2;
    localparam logic [2:0] REG_STATUS  = 3'd3;
    localparam logic [2:0] REG_SCRATCH = 3'd4;
    localparam logic [2:0] REG_ID      = 3'd5;

    logic             ctrl_en;
    logic             ctrl_auto;
    logic             ctrl_irq_en;
    logic [7:0]       ctrl_prescale;
    logic [WIDTH-1:0] load_q;
    logic [WIDTH-1:0] value_q;
    logic             expired_q;
    logic [31:0]      scratch_q;
    logic [7:0]       presc_cnt;

    logic             hit;
    logic             wr_en;
    logic             rd_en;
    logic [2:0]       reg_sel;
    logic             tick;
    logic             at_zero;
    logic [31:0]      rd_data;
    logic             unused_addr_bits;

    assign unused_addr_bits = ^Paddr[1:0];

    assign hit     = Pselx && (Paddr[31:5] == BASE_ADDR[31:5]);
    assign wr_en   = hit && Penable && Pwrite;
    assign rd_en   = hit && !Penable && !Pwrite;
    assign reg_sel = Paddr[4:2];

    assign tick    = ctrl_en && (presc_cnt == ctrl_prescale);
    assign at_zero = (value_q == '0);

    // Both operands are flops, so irq has no path from the APB inputs.
    assign irq = expired_q && ctrl_irq_en;

    // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
    always_comb begin
        rd_data = '0;
        case (reg_sel)
            REG_CTRL:    rd_data = {16'd0, ctrl_prescale, 5'd0, ctrl_irq_en, ctrl_auto, ctrl_en};
            REG_LOAD:    rd_data[WIDTH-1:0] = load_q;
            REG_VALUE:   rd_data[WIDTH-1:0] = value_q;
            REG_STATUS:  rd_data[0] = expired_q;
            REG_SCRATCH: rd_data = scratch_q;
            REG_ID:      rd_data = ID_VALUE;
            default:     rd_data = '0;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge Hclk or negedge Hrstn) begin
        if (!Hrstn) begin
            ctrl_en       <= 1'b0;
            ctrl_auto     <= 1'b0;
            ctrl_irq_en   <= 1'b0;
            ctrl_prescale <= '0;
        end else if (wr_en && reg_sel == REG_CTRL) begin
            // A software write takes priority over the one-shot hardware EN clear.
            ctrl_en       <= Pwdata[0];
            ctrl_auto     <= Pwdata[1];
            ctrl_irq_en   <= Pwdata[2];
            ctrl_prescale <= Pwdata[15:8];
        end else if (tick && at_zero && !ctrl_auto) begin
            ctrl_en <= 1'b0;
        end
    end

    always_ff @(posedge Hclk or negedge Hrstn) begin
        if (!Hrstn) begin
            load_q    <= '0;
            value_q   <= '0;
            presc_cnt <= '0;
        end else if (wr_en && reg_sel == REG_LOAD) begin
            load_q    <= Pwdata[WIDTH-1:0];
            value_q   <= Pwdata[WIDTH-1:0];
            presc_cnt <= '0;
        end else if (ctrl_en) begin
            presc_cnt <= tick ? 8'd0 : presc_cnt + 8'd1;
            if (tick) begin
                if (!at_zero)
                    value_q <= value_q - WIDTH'(1);
                else if (ctrl_auto)
                    value_q <= load_q;
            end
        end
    end

    // Expiry is suppressed by a same-edge LOAD write; a same-edge W1C loses to it.
    always_ff @(posedge Hclk or negedge Hrstn) begin
        if (!Hrstn)
            expired_q <= 1'b0;
        else if (tick && at_zero && !(wr_en && reg_sel == REG_LOAD))
            expired_q <= 1'b1;
        else if (wr_en && reg_sel == REG_STATUS && Pwdata[0])
            expired_q <= 1'b0;
    end

    // NOTE: every register here is a real flop with an async reset; nothing is left uninitialised.
    always_ff @(posedge Hclk or negedge Hrstn) begin
        if (!Hrstn)
            scratch_q <= '0;
        else if (wr_en && reg_sel == REG_SCRATCH)
            scratch_q <= Pwdata;
    end

    // Captured in the setup phase so the bridge sees a stable value in the enable phase.
    always_ff @(posedge Hclk or negedge Hrstn) begin
        if (!Hrstn)
            Prdata <= '0;
        else if (rd_en)
            Prdata <= rd_data;
    end

endmodule

// File: tb/tb_apb_timer_slave.sv
// Directed self-checking bench for apb_timer_slave; APB accesses are driven
// on the falling edge so every read lands on a known rising edge.
module tb_apb_timer_slave;

    logic        Hclk;
    logic        Hrstn;
    logic        Pselx;
    logic        Penable;
    logic        Pwrite;
    logic [31:0] Paddr;
    logic [31:0] Pwdata;
    logic [31:0] Prdata;
    logic        irq;

    int checks = 0;
    int errors = 0;

    localparam logic [31:0] A_CTRL    = 32'h00;
    localparam logic [31:0] A_LOAD    = 32'h04;
    localparam logic [31:0] A_VALUE   = 32'h08;
    localparam logic [31:0] A_STATUS  = 32'h0C;
    localparam logic [31:0] A_SCRATCH = 32'h10;
    localparam logic [31:0] A_ID      = 32'h14;

    apb_timer_slave #(
        .BASE_ADDR(32'h0000_0000),
        .WIDTH    (16),
        .ID_VALUE (32'hA9B0_0001)
    ) dut (
        .Hclk   (Hclk),
        .Hrstn  (Hrstn),
        .Pselx  (Pselx),
        .Penable(Penable),
        .Pwrite (Pwrite),
        .Paddr  (Paddr),
        .Pwdata (Pwdata),
        .Prdata (Prdata),
        .irq    (irq)
    );

    initial Hclk = 1'b0;
    always #5 Hclk = ~Hclk;

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, actual, expected);
        end
    endtask

    // Each access starts on a falling edge and ends on the falling edge after its enable edge.
    task automatic apb_write(input logic [31:0] addr, input logic [31:0] data);
        Pselx = 1'b1; Penable = 1'b0; Pwrite = 1'b1; Paddr = addr; Pwdata = data;
        @(posedge Hclk); @(negedge Hclk);
        Penable = 1'b1;
        @(posedge Hclk); @(negedge Hclk);
        Pselx = 1'b0; Penable = 1'b0;
    endtask

    task automatic apb_read(input logic [31:0] addr, output logic [31:0] data);
        Pselx = 1'b1; Penable = 1'b0; Pwrite = 1'b0; Paddr = addr;
        @(posedge Hclk); @(negedge Hclk);
        Penable = 1'b1;
        data = Prdata;
        @(posedge Hclk); @(negedge Hclk);
        Pselx = 1'b0; Penable = 1'b0;
    endtask

    task automatic read_check(input string tag, input logic [31:0] addr, input logic [31:0] expected);
        logic [31:0] rd;
        apb_read(addr, rd);
        check(tag, rd, expected);
    endtask

    initial begin
        Hrstn = 1'b0; Pselx = 1'b0; Penable = 1'b0; Pwrite = 1'b0;
        Paddr = '0; Pwdata = '0;

        // 1. reset and ID
        repeat (2) @(posedge Hclk);
        @(negedge Hclk);
        check("rst_prdata", Prdata, 32'h0);
        check("rst_irq", {31'd0, irq}, 32'h0);
        Hrstn = 1'b1;
        read_check("id", A_ID, 32'hA9B0_0001);
        read_check("ctrl_rst", A_CTRL, 32'h0);

        // 2. scratch, read-only VALUE, unmapped offset, decode miss
        apb_write(A_SCRATCH, 32'h0000_00FF);
        read_check("scratch", A_SCRATCH, 32'h0000_00FF);
        apb_write(A_VALUE, 32'd5);
        read_check("value_ro", A_VALUE, 32'h0);
        read_check("off_18", 32'h18, 32'h0);
        read_check("scratch_again", A_SCRATCH, 32'h0000_00FF);
        read_check("miss_rd", 32'h100, 32'h0000_00FF);
        apb_write(32'h110, 32'h1234_5678);
        read_check("miss_wr", A_SCRATCH, 32'h0000_00FF);

        // 3. one-shot: VALUE 3,2,1,0 then expiry clears EN and raises irq
        apb_write(A_LOAD, 32'd3);
        apb_write(A_CTRL, 32'h0000_0005);
        read_check("os_v3", A_VALUE, 32'd3);
        read_check("os_v1", A_VALUE, 32'd1);
        read_check("os_status", A_STATUS, 32'd1);
        read_check("os_en_clr", A_CTRL, 32'h0000_0004);
        read_check("os_v0", A_VALUE, 32'd0);
        check("os_irq", {31'd0, irq}, 32'd1);
        apb_write(A_STATUS, 32'd1);
        check("os_irq_drop", {31'd0, irq}, 32'd0);
        read_check("os_status_clr", A_STATUS, 32'd0);

        // 4. auto-reload with PRESCALE = 3: VALUE steps every 4 cycles
        apb_write(A_LOAD, 32'd2);
        apb_write(A_CTRL, 32'h0000_0303);
        read_check("ar_a", A_VALUE, 32'd2);
        read_check("ar_b", A_VALUE, 32'd2);
        read_check("ar_c", A_VALUE, 32'd1);
        read_check("ar_d", A_VALUE, 32'd1);
        read_check("ar_e", A_VALUE, 32'd0);
        read_check("ar_f", A_VALUE, 32'd0);
        read_check("ar_reload", A_VALUE, 32'd2);
        read_check("ar_status", A_STATUS, 32'd1);
        check("ar_irq", {31'd0, irq}, 32'd0);
        read_check("ar_ctrl", A_CTRL, 32'h0000_0303);

        // 5a. W1C on the expiry edge: set wins
        apb_write(A_CTRL, 32'h0);
        apb_write(A_STATUS, 32'd1);
        apb_write(A_LOAD, 32'd1);
        apb_write(A_CTRL, 32'h0000_0001);
        apb_write(A_STATUS, 32'd1);
        read_check("col_w1c", A_STATUS, 32'd1);

        // 5b. LOAD write on a tick edge: write wins, no decrement
        apb_write(A_STATUS, 32'd1);
        apb_write(A_LOAD, 32'd5);
        apb_write(A_CTRL, 32'h0000_0003);
        apb_write(A_LOAD, 32'd9);
        read_check("col_load", A_VALUE, 32'd9);
        apb_write(A_CTRL, 32'h0);

        // 5c. CTRL write on the hardware EN-clear edge: write wins
        apb_write(A_STATUS, 32'd1);
        apb_write(A_LOAD, 32'd1);
        apb_write(A_CTRL, 32'h0000_0001);
        apb_write(A_CTRL, 32'h0000_0005);
        read_check("col_ctrl", A_CTRL, 32'h0000_0005);
        check("col_irq", {31'd0, irq}, 32'd1);
        read_check("col_ctrl_hw", A_CTRL, 32'h0000_0004);

        // 6. async reset in the middle of a burst read
        apb_write(A_SCRATCH, 32'hA5A5_5A5A);
        apb_write(A_LOAD, 32'd0);
        apb_write(A_CTRL, 32'h0000_0007);
        read_check("burst_scratch", A_SCRATCH, 32'hA5A5_5A5A);
        read_check("burst_id", A_ID, 32'hA9B0_0001);
        check("burst_irq", {31'd0, irq}, 32'd1);
        Pselx = 1'b1; Penable = 1'b0; Pwrite = 1'b0; Paddr = A_SCRATCH;
        @(posedge Hclk);
        #2;
        Hrstn = 1'b0;
        #1;
        check("arst_prdata", Prdata, 32'h0);
        check("arst_irq", {31'd0, irq}, 32'd0);
        @(negedge Hclk);
        Pselx = 1'b0; Penable = 1'b0;
        @(negedge Hclk);
        Hrstn = 1'b1;
        read_check("arst_ctrl", A_CTRL, 32'h0);
        read_check("arst_load", A_LOAD, 32'h0);
        read_check("arst_scratch", A_SCRATCH, 32'h0);
        read_check("arst_status", A_STATUS, 32'h0);
        read_check("arst_value", A_VALUE, 32'h0);
        repeat (4) @(negedge Hclk);
        read_check("arst_stopped", A_STATUS, 32'h0);
        check("arst_irq_after", {31'd0, irq}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
